// File: rtl/thermostat_keypad.sv
`timescale 1ns/1ps
// thermostat_keypad
// Push-button front end for the thermostat controller. The three raw buttons are
// synchronised and debounced. Up/Down become paced step commands with
// press-and-hold auto-repeat. Set becomes a stretched pulse that the slower
// set/regulation clock domain can catch.
//
// Ports
//   slowclock1  in   clock, rising edge
//   Reset       in   asynchronous, active-high reset
//   btn_up      in   raw Up button (asynchronous, active-high)
//   btn_down    in   raw Down button (asynchronous, active-high)
//   btn_set     in   raw Set button (asynchronous, active-high)
//   Up          out  step-up command
//   Down        out  step-down command
//   Set         out  setpoint-commit command, SET_HOLD ticks wide
//   repeating   out  high while auto-repeat is active
//   conflict    out  high while both directions are held
//
// Build option: THERMOSTAT_KEYPAD_ACCEL_EN compiles in the FAST phase. In FAST
// the step output is held high continuously after FAST_AFTER repeat pulses.
// Without the option, REPEAT keeps pulsing every REPEAT_PERIOD ticks.
//
// state       | meaning
// S_IDLE      | no direction active, waiting for a debounced press
// S_FIRST     | first step pulse is on the output
// S_WAIT_HOLD | counting the hold delay before auto-repeat
// S_REPEAT    | pulsing every REPEAT_PERIOD ticks
// S_FAST      | step output held high (accelerated build only)
// S_CONFLICT  | both directions held, outputs suppressed
module thermostat_keypad #(
   parameter int unsigned DEB_TICKS     = 2,
   parameter int unsigned HOLD_DELAY    = 5,
   parameter int unsigned REPEAT_PERIOD = 2,
   parameter int unsigned FAST_AFTER    = 4,
   parameter int unsigned SET_HOLD      = 8
) (
   input  logic slowclock1,
   input  logic Reset,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_set,
   output logic Up,
   output logic Down,
   output logic Set,
   output logic repeating,
   output logic conflict
);

   localparam logic [3:0] DEB_LAST  = 4'(DEB_TICKS - 1);
   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_DELAY - 1);
   localparam logic [7:0] REP_LOAD  = 8'(REPEAT_PERIOD - 1);
   localparam logic [7:0] SET_LOAD  = 8'(SET_HOLD);
`ifdef THERMOSTAT_KEYPAD_ACCEL_EN
   localparam logic [7:0] FAST_LAST = 8'(FAST_AFTER);
`endif

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FIRST     = 3'd1,
      S_WAIT_HOLD = 3'd2,
      S_REPEAT    = 3'd3,
`ifdef THERMOSTAT_KEYPAD_ACCEL_EN
      S_FAST      = 3'd4,
`endif
      S_CONFLICT  = 3'd5
   } state_t;

   // bit 0 = up, bit 1 = down, bit 2 = set
   logic [2:0]      w_raw;
   logic [2:0]      r_sync1;
   logic [2:0]      r_sync2;
   logic [2:0]      r_deb;
   logic [2:0][3:0] r_deb_cnt;

   logic            r_set_prev;
   logic [7:0]      r_set_cnt;
   logic            w_set_rise;
   logic            w_set_block;

   state_t          r_state;
   logic            r_dir;      // 0 = up, 1 = down
   logic [7:0]      r_tick;
`ifdef THERMOSTAT_KEYPAD_ACCEL_EN
   logic [7:0]      r_rep;
`endif
   logic            r_up;
   logic            r_down;
   logic            r_repeating;
   logic            r_conflict;
   logic            w_du;
   logic            w_dd;
   logic            w_held;

   assign w_raw = {btn_set, btn_down, btn_up};

   always_ff @(posedge slowclock1 or posedge Reset) begin
      if (Reset) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_deb     <= '0;
         r_deb_cnt <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_deb_cnt[i] <= 4'd0;
            end else if (r_deb_cnt[i] == DEB_LAST) begin
               r_deb[i]     <= ~r_deb[i];
               r_deb_cnt[i] <= 4'd0;
            end else begin
               r_deb_cnt[i] <= r_deb_cnt[i] + 4'd1;
            end
         end
      end
   end

   assign w_set_rise  = r_deb[2] & ~r_set_prev;
   // The rise itself also blocks, so Set wins when it lands with an Up/Down press.
   assign w_set_block = w_set_rise | (r_set_cnt != 8'd0);
   assign Set         = (r_set_cnt != 8'd0);

   always_ff @(posedge slowclock1 or posedge Reset) begin
      if (Reset) begin
         r_set_prev <= 1'b0;
         r_set_cnt  <= 8'd0;
      end else begin
         r_set_prev <= r_deb[2];
         if (r_set_cnt != 8'd0) begin
            r_set_cnt <= r_set_cnt - 8'd1;
         end else if (w_set_rise) begin
            r_set_cnt <= SET_LOAD;
         end
      end
   end

   assign w_du   = r_deb[0];
   assign w_dd   = r_deb[1];
   assign w_held = r_dir ? w_dd : w_du;

   always_ff @(posedge slowclock1 or posedge Reset) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_dir       <= 1'b0;
         r_tick      <= 8'd0;
`ifdef THERMOSTAT_KEYPAD_ACCEL_EN
         r_rep       <= 8'd0;
`endif
         r_up        <= 1'b0;
         r_down      <= 1'b0;
         r_repeating <= 1'b0;
         r_conflict  <= 1'b0;
      end else begin
         r_up        <= 1'b0;
         r_down      <= 1'b0;
         r_repeating <= 1'b0;
         r_conflict  <= 1'b0;
         if (w_set_block) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_du & w_dd) begin
                     r_state    <= S_CONFLICT;
                     r_conflict <= 1'b1;
                  end else if (w_du | w_dd) begin
                     r_state <= S_FIRST;
                     r_dir   <= ~w_du;
                     r_up    <= w_du;
                     r_down  <= ~w_du;
                     r_tick  <= HOLD_LOAD;
                  end
               end
               S_CONFLICT: begin
                  if (!w_du && !w_dd) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_conflict <= 1'b1;
                  end
               end
               default: begin
                  if (w_du & w_dd) begin
                     r_state    <= S_CONFLICT;
                     r_conflict <= 1'b1;
                  end else if (!w_held) begin
                     r_state <= S_IDLE;
                  end else begin
                     case (r_state)
                        S_FIRST: begin
                           r_state <= S_WAIT_HOLD;
                           r_tick  <= r_tick - 8'd1;
                        end
                        S_WAIT_HOLD: begin
                           if (r_tick == 8'd0) begin
                              r_state     <= S_REPEAT;
                              r_up        <= ~r_dir;
                              r_down      <= r_dir;
                              r_repeating <= 1'b1;
                              r_tick      <= REP_LOAD;
`ifdef THERMOSTAT_KEYPAD_ACCEL_EN
                              r_rep       <= 8'd1;
`endif
                           end else begin
                              r_tick <= r_tick - 8'd1;
                           end
                        end
                        S_REPEAT: begin
                           r_repeating <= 1'b1;
                           if (r_tick == 8'd0) begin
                              r_up   <= ~r_dir;
                              r_down <= r_dir;
`ifdef THERMOSTAT_KEYPAD_ACCEL_EN
                              if (r_rep == FAST_LAST) begin
                                 r_state <= S_FAST;
                              end else begin
                                 r_tick <= REP_LOAD;
                                 if (r_rep != 8'hFF) r_rep <= r_rep + 8'd1;
                              end
`else
                              r_tick <= REP_LOAD;
`endif
                           end else begin
                              r_tick <= r_tick - 8'd1;
                           end
                        end
`ifdef THERMOSTAT_KEYPAD_ACCEL_EN
                        S_FAST: begin
                           r_up        <= ~r_dir;
                           r_down      <= r_dir;
                           r_repeating <= 1'b1;
                        end
`endif
                        default: r_state <= S_IDLE;
                     endcase
                  end
               end
            endcase
         end
      end
   end

   assign Up        = r_up;
   assign Down      = r_down;
   assign repeating = r_repeating;
   assign conflict  = r_conflict;

endmodule
